// File: rtl/instr_mem_boot.sv
// instr_mem_boot: synchronous instruction memory with an in-system boot loader.
// A host streams program words over a valid/ready port into consecutive
// addresses starting at 0; the fetch stage reads with one cycle of registered
// latency, and only while the loader is idle (READY).
// Optional feature macro: INSTR_MEM_PARITY_EN adds one even-parity bit per word
// and reports a mismatch on every read through rd_parity_err.
module instr_mem_boot #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter     INIT_FILE      = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_start,
    input  logic [ADDR_W:0]   boot_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              boot_busy,
    output logic              boot_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_parity_err
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_READY = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   ptr_r, ptr_s;
    logic [ADDR_W:0]     cnt_r, cnt_s;
    logic [ADDR_W:0]     len_r, len_s;
    logic [ADDR_W:0]     len_clamp_s;
    logic                done_s;
    logic                we_s;
    logic [DATA_W-1:0]   wdata_s;
    logic                boot_done_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic                rd_valid_r;
    logic                rd_parity_err_r;

    logic [DATA_W-1:0]   mem_r [DEPTH];

`ifdef INSTR_MEM_PARITY_EN
    logic [DEPTH-1:0]    par_r;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic parity_f(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    // Next-state, pointer/count and write-port control.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        cnt_s       = cnt_r;
        len_s       = len_r;
        done_s      = 1'b0;
        we_s        = 1'b0;
        wdata_s     = {DATA_W{1'b0}};
        len_clamp_s = (boot_len > DEPTH_LEN) ? DEPTH_LEN : boot_len;
        case (state_r)
            ST_CLEAR: begin
                we_s = 1'b1;
                if (ptr_r == ADDR_MAX) begin
                    state_s = ST_READY;
                    ptr_s   = {ADDR_W{1'b0}};
                end else begin
                    ptr_s = ptr_r + ADDR_ONE;
                end
            end
            ST_READY: begin
                if (boot_start) begin
                    len_s = len_clamp_s;
                    ptr_s = {ADDR_W{1'b0}};
                    cnt_s = {(ADDR_W+1){1'b0}};
                    if (len_clamp_s == {(ADDR_W+1){1'b0}}) begin
                        done_s = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    we_s    = 1'b1;
                    wdata_s = ld_data;
                    cnt_s   = cnt_r + CNT_ONE;
                    if ((cnt_r + CNT_ONE) == len_r) begin
                        // Last word: leave ptr in place so it never wraps.
                        state_s = ST_READY;
                        done_s  = 1'b1;
                    end else begin
                        ptr_s = ptr_r + ADDR_ONE;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            default: begin
                state_s = ST_CLEAR;
                ptr_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Control registers; reset restarts CLEAR (or goes straight to READY).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            ptr_r       <= {ADDR_W{1'b0}};
            cnt_r       <= {(ADDR_W+1){1'b0}};
            len_r       <= {(ADDR_W+1){1'b0}};
            boot_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            cnt_r       <= cnt_s;
            len_r       <= len_s;
            boot_done_r <= done_s;
        end
    end

    // Single write port shared by CLEAR (zeros) and LOAD (host words).
    always_ff @(posedge clk) begin
        if (rst_n && we_s) begin
            mem_r[ptr_r] <= wdata_s;
`ifdef INSTR_MEM_PARITY_EN
            par_r[ptr_r] <= parity_f(wdata_s);
`endif
        end
    end

    // Registered read port, serviced only while the loader is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_r       <= {DATA_W{1'b0}};
            rd_valid_r      <= 1'b0;
            rd_parity_err_r <= 1'b0;
        end else if (rd_en && (state_r == ST_READY)) begin
            rd_data_r       <= mem_r[rd_addr];
            rd_valid_r      <= 1'b1;
`ifdef INSTR_MEM_PARITY_EN
            rd_parity_err_r <= par_r[rd_addr] != parity_f(mem_r[rd_addr]);
`else
            rd_parity_err_r <= 1'b0;
`endif
        end else begin
            rd_valid_r      <= 1'b0;
            rd_parity_err_r <= 1'b0;
        end
    end

    assign ld_ready      = (state_r == ST_LOAD);
    assign boot_busy     = (state_r == ST_CLEAR) || (state_r == ST_LOAD);
    assign boot_done     = boot_done_r;
    assign rd_data       = rd_data_r;
    assign rd_valid      = rd_valid_r;
    assign rd_parity_err = rd_parity_err_r;

endmodule

// File: tb/tb_instr_mem_boot.sv
// Self-checking bench for instr_mem_boot: directed sequences plus a read-back table.
module tb_instr_mem_boot;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_start;
    logic [8:0]  boot_len;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        boot_busy;
    logic        boot_done;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_parity_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } rvec_t;

    rvec_t       tbl [16];
    logic [31:0] prog [14];

    instr_mem_boot dut (
        .clk(clk), .rst_n(rst_n), .boot_start(boot_start), .boot_len(boot_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .boot_busy(boot_busy), .boot_done(boot_done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_parity_err(rd_parity_err)
    );

    always #5 clk = ~clk;

    // Count every boot_done cycle, sampled away from the active edge.
    always @(negedge clk) begin
        if (boot_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic read_word(input string name, input logic [7:0] a, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        check_bit({name, "_valid"}, rd_valid, 1'b1);
        check(name, rd_data, exp);
    endtask

    // Wait for CLEAR to finish; rd_en stays high to show reads are ignored.
    task automatic wait_clear(input string name, input int exp_cycles);
        int  n = 0;
        logic saw_valid = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 8'd0;
        do begin
            tick();
            n++;
            if (rd_valid) saw_valid = 1'b1;
        end while (boot_busy && n < 400);
        rd_en = 1'b0;
        check(name, 32'(n), 32'(exp_cycles));
        check_bit({name, "_no_read"}, saw_valid, 1'b0);
    endtask

    initial begin
        int          sent;
        int          cyc;
        int          acc;
        int          done_base;
        logic        rdy;
        logic        rv_seen;
        logic [15:0] gap;

        prog[0]  = 32'h0000_8020; prog[1]  = 32'h2010_0078; prog[2]  = 32'h2011_0005;
        prog[3]  = 32'h0211_4020; prog[4]  = 32'hAD09_0004; prog[5]  = 32'h8D0A_0004;
        prog[6]  = 32'h0149_5022; prog[7]  = 32'h114A_0002; prog[8]  = 32'h2129_0001;
        prog[9]  = 32'h0800_0003; prog[10] = 32'h3C0B_1234; prog[11] = 32'h356B_5678;
        prog[12] = 32'h0160_6020; prog[13] = 32'hAC12_0000;
        tbl[0]  = {8'd0,   32'h0000_8020}; tbl[1]  = {8'd1,   32'h2010_0078};
        tbl[2]  = {8'd2,   32'h2011_0005}; tbl[3]  = {8'd3,   32'h0211_4020};
        tbl[4]  = {8'd4,   32'hAD09_0004}; tbl[5]  = {8'd5,   32'h8D0A_0004};
        tbl[6]  = {8'd6,   32'h0149_5022}; tbl[7]  = {8'd7,   32'h114A_0002};
        tbl[8]  = {8'd8,   32'h2129_0001}; tbl[9]  = {8'd9,   32'h0800_0003};
        tbl[10] = {8'd10,  32'h3C0B_1234}; tbl[11] = {8'd11,  32'h356B_5678};
        tbl[12] = {8'd12,  32'h0160_6020}; tbl[13] = {8'd13,  32'hAC12_0000};
        tbl[14] = {8'd14,  32'h0000_0000}; tbl[15] = {8'd255, 32'h0000_0000};

        rst_n = 1'b0; boot_start = 1'b0; boot_len = 9'd0; ld_valid = 1'b0;
        ld_data = 32'd0; rd_en = 1'b0; rd_addr = 8'd0;

        // 1. reset and CLEAR
        tick(); tick();
        check_bit("rst_busy", boot_busy, 1'b1);
        check_bit("rst_ready", ld_ready, 1'b0);
        check_bit("rst_valid", rd_valid, 1'b0);
        check_bit("rst_done", boot_done, 1'b0);
        check("rst_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        wait_clear("clear_cycles", 256);
        check_bit("ready_ld_ready", ld_ready, 1'b0);
        read_word("clear_rd5", 8'd5, 32'd0);
        tick();
        check_bit("rd_valid_drop", rd_valid, 1'b0);

        // 2. 14-word load, then table read-back (back-to-back reads)
        boot_start = 1'b1; boot_len = 9'd14; tick(); boot_start = 1'b0;
        check_bit("load_ready", ld_ready, 1'b1);
        check_bit("load_busy", boot_busy, 1'b1);
        for (int i = 0; i < 14; i++) begin
            ld_valid = 1'b1; ld_data = prog[i];
            tick();
        end
        ld_valid = 1'b0;
        check_bit("load14_done", boot_done, 1'b1);
        check_bit("load14_ready_off", ld_ready, 1'b0);
        tick();
        check_bit("load14_done_pulse", boot_done, 1'b0);
        check("load14_done_cnt", 32'(done_cnt), 32'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr = tbl[i].addr;
            tick();
            check_bit($sformatf("tbl%0d_valid", i), rd_valid, 1'b1);
            check($sformatf("tbl%0d_data", i), rd_data, tbl[i].data);
            check_bit($sformatf("tbl%0d_perr", i), rd_parity_err, 1'b0);
        end
        rd_en = 1'b0;
        tick();

        // 3. gapped load with reads requested throughout; start coincides with a read
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        rd_en = 1'b1; rd_addr = 8'd0;
        boot_start = 1'b1; boot_len = 9'd6;
        tick();
        boot_start = 1'b0;
        check_bit("start_read_valid", rd_valid, 1'b1);
        check("start_read_old", rd_data, 32'h0000_8020);
        gap = 16'b1011_0010_1101_0011;
        sent = 0; cyc = 0; rv_seen = 1'b0;
        while (sent < 6 && cyc < 16) begin
            ld_valid = gap[cyc];
            ld_data  = 32'hC0DE_0000 + 32'(sent);
            rd_addr  = 8'(cyc);
            rdy = ld_ready;
            tick();
            if (ld_valid && rdy) sent++;
            if (rd_valid) rv_seen = 1'b1;
            cyc++;
        end
        ld_valid = 1'b0; rd_en = 1'b0;
        check("gap_sent", 32'(sent), 32'd6);
        check_bit("gap_no_read", rv_seen, 1'b0);
        check_bit("gap_done", boot_done, 1'b1);
        tick();
        check("gap_done_cnt", 32'(done_cnt), 32'd2);
        read_word("gap_rd0", 8'd0, 32'hC0DE_0000);
        read_word("gap_rd5", 8'd5, 32'hC0DE_0005);
        read_word("gap_rd6", 8'd6, 32'h0149_5022);

        // 4a. zero-length load
        boot_start = 1'b1; boot_len = 9'd0; tick(); boot_start = 1'b0;
        check_bit("len0_done", boot_done, 1'b1);
        check_bit("len0_busy", boot_busy, 1'b0);
        check_bit("len0_ready", ld_ready, 1'b0);
        tick();
        check_bit("len0_pulse", boot_done, 1'b0);
        check("len0_done_cnt", 32'(done_cnt), 32'd3);
        read_word("len0_rd0", 8'd0, 32'hC0DE_0000);

        // 4b. oversize load clamps to the depth
        boot_start = 1'b1; boot_len = 9'd300; tick(); boot_start = 1'b0;
        acc = 0; ld_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ld_data = 32'h1000_0000 + 32'(acc);
            rdy = ld_ready;
            tick();
            if (rdy) acc++;
            if (!ld_ready) break;
        end
        tick();
        ld_valid = 1'b0;
        check("len300_accepted", 32'(acc), 32'd256);
        check_bit("len300_ready_off", ld_ready, 1'b0);
        check("len300_done_cnt", 32'(done_cnt), 32'd4);
        read_word("len300_rd0", 8'd0, 32'h1000_0000);
        read_word("len300_rd255", 8'd255, 32'h1000_00FF);

        // 5. reset after the fifth LOAD word
        done_base = done_cnt;
        boot_start = 1'b1; boot_len = 9'd14; tick(); boot_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_data = 32'hBAD0_0000 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check_bit("abort_busy", boot_busy, 1'b1);
        wait_clear("abort_clear", 256);
        read_word("abort_rd0", 8'd0, 32'd0);
        read_word("abort_rd4", 8'd4, 32'd0);
        tick();
        check("abort_no_done", 32'(done_cnt), 32'(done_base));

`ifdef INSTR_MEM_PARITY_EN
        // 6. corrupted stored word is flagged on read
        dut.mem_r[3][0] = ~dut.mem_r[3][0];
        read_word("par_rd3", 8'd3, 32'd1);
        check_bit("par_err3", rd_parity_err, 1'b1);
        read_word("par_rd4", 8'd4, 32'd0);
        check_bit("par_err4", rd_parity_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
